data_bus: RTL

- Data-side memory system that sits directly downstream of the CPU's data port. It consumes data_addr, data_out and mem_write_en, and returns data_in.
- Address space is split in two:
  - Words below MMIO_BASE decode to an internal word RAM, which holds the data area and the stack.
  - Words from MMIO_BASE upward decode to memory-mapped registers: a transmit FIFO with a valid/ready drain port, a status register, a strobe-driven timer and an LED register.

---
 rtl/data_bus.sv | 118 +++++++++++
 1 files changed

// File: rtl/data_bus.sv
// rtl/data_bus.sv - CPU data-side memory system: word RAM plus MMIO TX FIFO, status, timer and LEDs.
// Writes commit on the CPU step strobe; reads are registered every clk from the current address.
module data_bus #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    RAM_AW     = 11,
  parameter logic [WORD_WIDTH-1:0] MMIO_BASE  = 16'hF800,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_stb_800k,
  input  logic [WORD_WIDTH-1:0] data_addr,
  input  logic [WORD_WIDTH-1:0] data_out,
  input  logic                  mem_write_en,
  output logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] leds
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] ram    [2**RAM_AW];
  logic [WORD_WIDTH-1:0] fifo_q [FIFO_DEPTH];

  logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [WORD_WIDTH-1:0] timer_q, timer_d;
  logic [WORD_WIDTH-1:0] leds_q, leds_d;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [WORD_WIDTH-1:0] data_in_q, data_in_d;

  logic                  wr, is_mmio, full, empty, pop, push;
  logic                  wr_tx, wr_stat, wr_tmr, wr_led;
  logic [WORD_WIDTH-1:0] off, status;
  logic [3:0]            cnt_sat;

  assign wr      = clk_stb_800k & mem_write_en;
  assign is_mmio = data_addr >= MMIO_BASE;
  assign off     = data_addr - MMIO_BASE;
  assign wr_tx   = wr & is_mmio & (off == WORD_WIDTH'(0));
  assign wr_stat = wr & is_mmio & (off == WORD_WIDTH'(1));
  assign wr_tmr  = wr & is_mmio & (off == WORD_WIDTH'(2));
  assign wr_led  = wr & is_mmio & (off == WORD_WIDTH'(3));

  assign full  = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign pop   = !empty & tx_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push  = wr_tx & (!full | pop);

  always_comb begin
    cnt_sat = 4'hF;
    if (32'(cnt_q) <= 15) cnt_sat = 4'(cnt_q);
  end

  assign status = WORD_WIDTH'({cnt_sat, 1'b0, ovf_q, full, empty});

  always_comb begin
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d   = ovf_q;
    if (wr_tx && full && !pop) ovf_d = 1'b1;
    if (wr_stat && data_out[2]) ovf_d = 1'b0;
    timer_d = clk_stb_800k ? timer_q + WORD_WIDTH'(1) : timer_q;
    if (wr_tmr) timer_d = data_out;
    leds_d  = wr_led ? data_out : leds_q;
    // The pushed word becomes the head when it lands on the slot the read pointer moves to.
    tx_data_d = (push && wptr_q == rptr_d) ? data_out : fifo_q[rptr_d];
    data_in_d = '0;
    if (!is_mmio) begin
      data_in_d = ram[data_addr[RAM_AW-1:0]];
    end else begin
      case (off)
        WORD_WIDTH'(1): data_in_d = status;
        WORD_WIDTH'(2): data_in_d = timer_q;
        WORD_WIDTH'(3): data_in_d = leds_q;
        default:        data_in_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !is_mmio) ram[data_addr[RAM_AW-1:0]] <= data_out;
    if (push) fifo_q[wptr_q] <= data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      leds_q    <= '0;
      tx_data_q <= '0;
      data_in_q <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      leds_q    <= leds_d;
      tx_data_q <= tx_data_d;
      data_in_q <= data_in_d;
    end
  end

  assign data_in  = data_in_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = !empty;
  assign leds     = leds_q;

endmodule
